// File: rtl/io_hub.sv
// io_hub: memory-mapped LED, debounced key and down-counting timer peripheral.
// Define IO_HUB_DEBOUNCE_EN to include the per-key debounce counters.
module io_hub #(
    parameter int KEY_W        = 1,
    parameter int LED_W        = 16,
    parameter int DEBOUNCE_CYC = 16,
    parameter int TIMER_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               we,
    input  logic [31:0]        addr,
    input  logic [31:0]        wtData,
    output logic [31:0]        rdData,
    input  logic [KEY_W-1:0]   key,
    output logic [LED_W-1:0]   led,
    output logic               intimer
);

    localparam logic [2:0] A_LED   = 3'd0;
    localparam logic [2:0] A_KST   = 3'd1;
    localparam logic [2:0] A_KEDGE = 3'd2;
    localparam logic [2:0] A_TCTRL = 3'd3;
    localparam logic [2:0] A_TLOAD = 3'd4;
    localparam logic [2:0] A_TCNT  = 3'd5;
    localparam logic [2:0] A_TSTAT = 3'd6;

    logic [2:0] sel;
    logic       wr;
    logic       wr_led, wr_kedge, wr_tctrl, wr_tload, wr_tstat;

    assign sel      = addr[4:2];
    assign wr       = ce & we;
    assign wr_led   = wr && (sel == A_LED);
    assign wr_kedge = wr && (sel == A_KEDGE);
    assign wr_tctrl = wr && (sel == A_TCTRL);
    assign wr_tload = wr && (sel == A_TLOAD);
    assign wr_tstat = wr && (sel == A_TSTAT);

    logic unused_addr;
    assign unused_addr = ^{addr[31:5], addr[1:0]};

    logic [LED_W-1:0] led_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg <= '0;
        end else if (wr_led) begin
            led_reg <= wtData[LED_W-1:0];
        end
    end

    assign led = led_reg;

    logic [KEY_W-1:0] sync1;
    logic [KEY_W-1:0] key_state;
    logic [KEY_W-1:0] key_nxt;
    logic [KEY_W-1:0] key_edge;
    logic [KEY_W-1:0] edge_clr;

`ifdef IO_HUB_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [KEY_W-1:0] sync2;
    logic [CW-1:0]    cnt [KEY_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync2 <= '0;
            for (int i = 0; i < KEY_W; i++) cnt[i] <= '0;
        end else begin
            sync2 <= sync1;
            for (int i = 0; i < KEY_W; i++) begin
                if (sync2[i] == key_state[i] || cnt[i] == CNT_LAST)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    // The last counting edge commits the synced level.
    always_comb begin
        key_nxt = key_state;
        for (int i = 0; i < KEY_W; i++) begin
            if (sync2[i] != key_state[i] && cnt[i] == CNT_LAST)
                key_nxt[i] = sync2[i];
        end
    end
`else
    logic unused_db;
    assign unused_db = ^DEBOUNCE_CYC;
    assign key_nxt   = sync1;
`endif

    assign edge_clr = wr_kedge ? wtData[KEY_W-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            key_state <= '0;
            key_edge  <= '0;
        end else begin
            sync1     <= key;
            key_state <= key_nxt;
            key_edge  <= (key_edge & ~edge_clr) | (key_nxt & ~key_state);
        end
    end

    logic               en, reload, ie, pend;
    logic [TIMER_W-1:0] tload, tcount;
    logic               fire;

    assign fire = en && (tcount == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en     <= 1'b0;
            reload <= 1'b0;
            ie     <= 1'b0;
            tload  <= '0;
            tcount <= '0;
            pend   <= 1'b0;
        end else begin
            if (en) begin
                if (fire) begin
                    if (reload) begin
                        tcount <= tload;
                    end else begin
                        tcount <= '0;
                        en     <= 1'b0;
                    end
                end else begin
                    tcount <= tcount - TIMER_W'(1);
                end
            end
            // Register writes take priority over the counting step.
            if (wr_tctrl) begin
                en     <= wtData[0];
                reload <= wtData[1];
                ie     <= wtData[2];
                if (wtData[0] && !en) tcount <= tload;
            end
            if (wr_tload) begin
                tload <= wtData[TIMER_W-1:0];
                if (en) tcount <= wtData[TIMER_W-1:0];
            end
            pend <= fire | (pend & ~(wr_tstat & wtData[0]));
        end
    end

    assign intimer = pend & ie;

    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (sel)
            A_LED:   rd_mux = 32'(led_reg);
            A_KST:   rd_mux = 32'(key_state);
            A_KEDGE: rd_mux = 32'(key_edge);
            A_TCTRL: rd_mux = {29'b0, ie, reload, en};
            A_TLOAD: rd_mux = 32'(tload);
            A_TCNT:  rd_mux = 32'(tcount);
            A_TSTAT: rd_mux = {31'b0, pend};
            default: rd_mux = '0;
        endcase
    end

    assign rdData = ce ? rd_mux : '0;

endmodule
